// File: rtl/oai21_triple_cell.sv
// Three independently built OAI21 gates, y = ~((a | b) & c), registered side by side.
// A cross-comparator flags any cycle where the registered copies disagree.
module oai21_triple_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic [2:0]       flt_inj,
    output logic             w1,
    output logic             w2,
    output logic             w5,
    output logic             mismatch,
    output logic [CNT_W-1:0] mis_cnt
);

    // Variant 1: OR -> AND -> inverter
    logic v1_or;
    logic v1_and;
    logic y1;
    assign v1_or  = a | b;
    assign v1_and = v1_or & c;
    assign y1     = ~v1_and;

    // Variant 2: NOR -> inverter -> NAND
    logic v2_nor;
    logic v2_or;
    logic y2;
    assign v2_nor = ~(a | b);
    assign v2_or  = ~v2_nor;
    assign y2     = ~(v2_or & c);

    // Variant 5: behavioural
    logic y5;
    assign y5 = ~((a | b) & c);

    logic             w1_q, w2_q, w5_q;
    logic             w1_d, w2_d, w5_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             disagree;

    // The comparator looks at the registered copies, so it lags the outputs by one edge.
    assign disagree = ~((w1_q == w2_q) & (w2_q == w5_q));

    always_comb begin
        w1_d       = y1 ^ flt_inj[0];
        w2_d       = y2 ^ flt_inj[1];
        w5_d       = y5 ^ flt_inj[2];
        mismatch_d = mismatch_q;
        mis_cnt_d  = mis_cnt_q;
        if (disagree) begin
            mismatch_d = 1'b1;
            if (mis_cnt_q != {CNT_W{1'b1}}) begin
                mis_cnt_d = mis_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w1_q       <= 1'b1;
            w2_q       <= 1'b1;
            w5_q       <= 1'b1;
            mismatch_q <= 1'b0;
            mis_cnt_q  <= '0;
        end else begin
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            w5_q       <= w5_d;
            mismatch_q <= mismatch_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign w1       = w1_q;
    assign w2       = w2_q;
    assign w5       = w5_q;
    assign mismatch = mismatch_q;
    assign mis_cnt  = mis_cnt_q;

endmodule

// File: tb/tb_oai21_triple_cell.sv
// Bench for oai21_triple_cell: a truth-table reference model pushes the expected
// post-edge state into a queue at every rising edge; a monitor pops and compares on the falling edge.
module tb_oai21_triple_cell;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W       = 4 + CNT_W;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a = 1'b0, b = 1'b0, c = 1'b0;
  logic [2:0]       flt_inj = 3'b000;
  logic             w1, w2, w5, mismatch;
  logic [CNT_W-1:0] mis_cnt;

  always #5 clk = ~clk;

  oai21_triple_cell #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .flt_inj  (flt_inj),
    .w1       (w1),
    .w2       (w2),
    .w5       (w5),
    .mismatch (mismatch),
    .mis_cnt  (mis_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Truth table indexed by {a,b,c}: 000..111 -> 1,1,1,0,1,0,1,0
  logic [7:0] truth_tbl = 8'b0101_0111;
  bit   [2:0] m_w   = 3'b111;  // [0]=w1, [1]=w2, [2]=w5
  bit         m_mis = 1'b0;
  int         m_cnt = 0;

  initial begin
    forever begin
      int ones;
      bit y;
      logic [CNT_W-1:0] cnt_v;
      @(posedge clk);
      if (!rst_n) begin
        m_w   = 3'b111;
        m_mis = 1'b0;
        m_cnt = 0;
      end else begin
        ones = int'(m_w[0]) + int'(m_w[1]) + int'(m_w[2]);
        if (ones != 0 && ones != 3) begin
          m_mis = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        y   = truth_tbl[{a, b, c}];
        m_w = {y, y, y} ^ flt_inj;
      end
      cnt_v = m_cnt[CNT_W-1:0];
      exp_q.push_back({m_w[0], m_w[1], m_w[2], m_mis, cnt_v});
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    forever begin
      logic [W-1:0] e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w1",       int'(w1),       int'(e[W-1]));
        check("w2",       int'(w2),       int'(e[W-2]));
        check("w5",       int'(w5),       int'(e[W-3]));
        check("mismatch", int'(mismatch), int'(e[W-4]));
        check("mis_cnt",  int'(mis_cnt),  int'(e[CNT_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] abc, input logic [2:0] flt, input logic rn);
    @(negedge clk);
    {a, b, c} = abc;
    flt_inj   = flt;
    rst_n     = rn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'($urandom_range(0, 7)), 3'b000, 1'b1);
  endtask

  // Inputs toggle at even offsets from a falling edge, so never on a rising edge.
  task automatic toggle_phase();
    @(negedge clk);
    flt_inj = 3'b000;
    fork
      repeat (6)  begin #90; a = ~a; end
      repeat (9)  begin #64; b = ~b; end
      repeat (11) begin #52; c = ~c; end
    join
    #24;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset with random data and faults
    for (int i = 0; i < 3; i++) drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);

    // Exhaustive sweep, no faults
    for (int i = 0; i < 8; i++) drive(3'(i), 3'b000, 1'b1);
    idle(2);

    toggle_phase();
    idle(2);

    // Single fault on variant 2
    drive(3'b101, 3'b010, 1'b1);
    idle(4);

    // Saturation, then all-three faults add nothing
    drive(3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) drive(3'($urandom_range(0, 7)), 3'b001, 1'b1);
    for (int i = 0; i < 4; i++) drive(3'($urandom_range(0, 7)), 3'b111, 1'b1);
    idle(2);

    // Mid-run reset with the counter at 2
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b011, 3'b001, 1'b1);
    drive(3'b011, 3'b001, 1'b1);
    idle(2);
    drive(3'b111, 3'b100, 1'b0);
    idle(3);

    // Random traffic: rare faults and occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [2:0] f;
      logic       rn;
      f  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rn = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      drive(3'($urandom_range(0, 7)), f, rn);
    end
    idle(3);

    // Drain: the model pushes one entry per edge and the monitor pops one per edge
    for (int i = 0; i < 10 && exp_q.size() > 1; i++) @(negedge clk);
    check("queue_drained", (exp_q.size() <= 1) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
